// File: rtl/rv32i_prog_loader_if.sv
// rv32i_prog_loader_if: instruction beat stream in, instruction memory write port out
interface rv32i_prog_loader_if #(parameter int ADDR_W = 10);
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        in_opcode;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    modport master (output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last,
                    input in_ready, imem_we, imem_addr, imem_wdata);
    modport slave (input in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last,
                   output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/rv32i_prog_loader.sv
// rv32i_prog_loader: encodes RV32I field beats into instruction words and writes them to imem in order
module rv32i_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    rv32i_prog_loader_if.slave  bus,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [ADDR_W:0]     count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d, done_q, done_d, err_q, err_d;
    logic [1:0]        code_q, code_d, code;
    logic              is_r, is_i, is_s, is_b, is_j, is_sh, imm_ok, acc;
    logic [6:0]        op, f7;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        f3;
    logic [31:0]       imm, word;
    logic signed [31:0] simm;

    assign op   = bus.in_opcode;
    assign f7   = bus.in_funct7;
    assign f3   = bus.in_funct3;
    assign rd   = bus.in_rd;
    assign rs1  = bus.in_rs1;
    assign rs2  = bus.in_rs2;
    assign imm  = bus.in_imm;
    assign simm = bus.in_imm;

    assign is_r  = op == OP_R;
    assign is_i  = op == OP_IMM || op == OP_LOAD || op == OP_JALR;
    assign is_s  = op == OP_STORE;
    assign is_b  = op == OP_BRANCH;
    assign is_j  = op == OP_JAL;
    assign is_sh = op == OP_IMM && f3[1:0] == 2'b01;

    assign imm_ok = is_sh ? (simm >= 0 && simm <= 31) :
                    (is_i || is_s) ? (simm >= -2048 && simm <= 2047) :
                    is_b ? (simm >= -4096 && simm <= 4094 && !imm[0]) :
                    is_j ? (simm >= -1048576 && simm <= 1048574 && !imm[0]) : 1'b1;

    // count can never exceed 2^ADDR_W, so its top bit alone flags a full memory
    assign code = !(is_r || is_i || is_s || is_b || is_j) ? 2'b01 :
                  !imm_ok ? 2'b10 :
                  count_q[ADDR_W] ? 2'b11 : 2'b00;

    assign word = is_r  ? {f7, rs2, rs1, f3, rd, op} :
                  is_sh ? {f7, imm[4:0], rs1, f3, rd, op} :
                  is_i  ? {imm[11:0], rs1, f3, rd, op} :
                  is_s  ? {imm[11:5], rs2, rs1, f3, imm[4:0], op} :
                  is_b  ? {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op} :
                          {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};

    assign bus.in_ready = state_q == S_LOAD;
    assign acc = bus.in_valid && state_q == S_LOAD;

    // start restarts the bookkeeping but leaves a same-cycle beat's write intact
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        code_d  = code_q;
        if (acc && code != 2'b00) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            code_d  = code;
        end else if (acc) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = word;
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W+1)'(1);
            state_d = bus.in_last ? S_DONE : S_LOAD;
            done_d  = bus.in_last;
        end
        if (start) begin
            state_d = S_LOAD;
            count_d = '0;
            ptr_d   = ADDR_W'(BASE_ADDR);
            done_d  = 1'b0;
            err_d   = 1'b0;
            code_d  = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            ptr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy     = state_q == S_LOAD;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = code_q;
    assign count    = count_q;
endmodule

// File: tb/tb_rv32i_prog_loader.sv
// tb_rv32i_prog_loader: directed vector table, corner sequences and a randomized run against a reference model
module tb_rv32i_prog_loader;
    logic clk = 1'b0;
    logic rst, start, start2;
    logic busy, done, err, busy2, done2, err2;
    logic [1:0] err_code, err_code2;
    logic [10:0] count;
    logic [2:0] count2;
    int checks = 0;
    int errors = 0;

    rv32i_prog_loader_if #(.ADDR_W(10)) bus();
    rv32i_prog_loader_if #(.ADDR_W(2))  bus2();

    rv32i_prog_loader #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count));

    rv32i_prog_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk(clk), .rst(rst), .start(start2), .bus(bus2.slave),
        .busy(busy2), .done(done2), .err(err2), .err_code(err_code2), .count(count2));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        last;
        logic [31:0] word;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[14];

    // reference model: 0 idle, 1 load, 2 done, 3 err
    int m_state = 0, m_count = 0, m_ptr = 0;
    logic        e_we = 0, e_done = 0, e_err = 0;
    logic [1:0]  e_code = 0;
    logic [9:0]  e_addr = 0;
    logic [31:0] e_wdata = 0;

    function automatic vec_t mk(string n, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic [2:0] f3, logic [6:0] f7, logic [31:0] imm, logic last,
                                logic [31:0] word, logic [1:0] code);
        vec_t v;
        v.name = n; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.last = last; v.word = word; v.code = code;
        return v;
    endfunction

    function automatic void ref_enc(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] u, output logic [1:0] code, output logic [31:0] w);
        int v, lo, hi, fmt;
        logic even, shift;
        logic [31:0] base;
        v = $signed(u);
        shift = op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5);
        case (op)
            7'h33: fmt = 0;
            7'h13, 7'h03, 7'h67: fmt = 1;
            7'h23: fmt = 2;
            7'h63: fmt = 3;
            7'h6F: fmt = 4;
            default: fmt = -1;
        endcase
        lo = -2048; hi = 2047; even = 0;
        if (fmt == 3) begin lo = -4096; hi = 4094; even = 1; end
        if (fmt == 4) begin lo = -1048576; hi = 1048574; even = 1; end
        if (shift) begin lo = 0; hi = 31; end
        base = (32'(rs1) << 15) + (32'(f3) << 12) + 32'(op);
        case (fmt)
            0: w = (32'(f7) << 25) + (32'(rs2) << 20) + base + (32'(rd) << 7);
            1: w = shift ? (32'(f7) << 25) + ((u & 32'h1F) << 20) + base + (32'(rd) << 7)
                         : ((u & 32'hFFF) << 20) + base + (32'(rd) << 7);
            2: w = (((u >> 5) & 32'h7F) << 25) + (32'(rs2) << 20) + base + ((u & 32'h1F) << 7);
            3: w = (((u >> 12) & 1) << 31) + (((u >> 5) & 32'h3F) << 25) + (32'(rs2) << 20) + base
                   + (((u >> 1) & 32'hF) << 8) + (((u >> 11) & 1) << 7);
            default: w = (((u >> 20) & 1) << 31) + (((u >> 1) & 32'h3FF) << 21) + (((u >> 11) & 1) << 20)
                         + (((u >> 12) & 32'hFF) << 12) + (32'(rd) << 7) + 32'(op);
        endcase
        if (fmt < 0) code = 2'd1;
        else if (fmt != 0 && (v < lo || v > hi || (even && v % 2 != 0))) code = 2'd2;
        else code = 2'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        logic [1:0] c;
        logic [31:0] w;
        chk("in_ready", 32'(bus.in_ready), 32'(m_state == 1));
        if (rst) begin
            m_state = 0; m_count = 0; m_ptr = 0;
            e_we = 0; e_addr = 0; e_wdata = 0; e_done = 0; e_err = 0; e_code = 0;
        end else begin
            e_we = 0;
            if (bus.in_valid && m_state == 1) begin
                ref_enc(bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_funct3, bus.in_funct7,
                        bus.in_imm, c, w);
                if (c == 0 && m_count == 1024) c = 2'd3;
                if (c != 0) begin
                    m_state = 3; e_err = 1; e_code = c;
                end else begin
                    e_we = 1; e_addr = 10'(m_ptr); e_wdata = w;
                    m_ptr = (m_ptr + 1) % 1024; m_count++;
                    if (bus.in_last) begin m_state = 2; e_done = 1; end
                end
            end
            if (start) begin
                m_state = 1; m_count = 0; m_ptr = 0; e_done = 0; e_err = 0; e_code = 0;
            end
        end
        @(posedge clk); #1;
        chk("imem_we", 32'(bus.imem_we), 32'(e_we));
        chk("imem_addr", 32'(bus.imem_addr), 32'(e_addr));
        chk("imem_wdata", bus.imem_wdata, e_wdata);
        chk("busy", 32'(busy), 32'(m_state == 1));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("err_code", 32'(err_code), 32'(e_code));
        chk("count", 32'(count), 32'(m_count));
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid = 1; bus.in_opcode = v.op; bus.in_rd = v.rd; bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2;
        bus.in_funct3 = v.f3; bus.in_funct7 = v.f7; bus.in_imm = v.imm; bus.in_last = v.last;
    endtask

    task automatic pulse_start();
        start = 1; cycle(); start = 0;
    endtask

    int bnd[18] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                    -1048577, -1048576, 1048574, 1048575, 1048576, 0, 31, 32, -1};
    logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h7F};

    initial begin
        vecs[0]  = mk("addi",     7'h13, 1, 0, 0, 3'd0, 7'h00, 32'd5,     0, 32'h00500093, 2'd0);
        vecs[1]  = mk("sw",       7'h23, 0, 1, 2, 3'd2, 7'h00, 32'd8,     0, 32'h0020A423, 2'd0);
        vecs[2]  = mk("beq",      7'h63, 0, 1, 2, 3'd0, 7'h00, -32'sd4,   0, 32'hFE208EE3, 2'd0);
        vecs[3]  = mk("jal",      7'h6F, 1, 0, 0, 3'd0, 7'h00, 32'd8,     1, 32'h008000EF, 2'd0);
        vecs[4]  = mk("addi_big", 7'h13, 1, 0, 0, 3'd0, 7'h00, 32'd2048,  0, 32'h0,        2'd2);
        vecs[5]  = mk("lui",      7'h37, 1, 0, 0, 3'd0, 7'h00, 32'd0,     0, 32'h0,        2'd1);
        vecs[6]  = mk("br_odd",   7'h63, 0, 1, 2, 3'd0, 7'h00, 32'd3,     0, 32'h0,        2'd2);
        vecs[7]  = mk("slli",     7'h13, 3, 1, 0, 3'd1, 7'h00, 32'd5,     0, 32'h00509193, 2'd0);
        vecs[8]  = mk("srai_32",  7'h13, 3, 1, 0, 3'd5, 7'h20, 32'd32,    0, 32'h0,        2'd2);
        vecs[9]  = mk("add",      7'h33, 3, 1, 2, 3'd0, 7'h00, 32'd0,     0, 32'h002081B3, 2'd0);
        vecs[10] = mk("jal_odd",  7'h6F, 1, 0, 0, 3'd0, 7'h00, 32'd7,     0, 32'h0,        2'd2);
        vecs[11] = mk("jal_max",  7'h6F, 0, 0, 0, 3'd0, 7'h00, 32'd1048574, 0, 32'h7FFFF06F, 2'd0);
        vecs[12] = mk("lw_min",   7'h03, 5, 2, 0, 3'd2, 7'h00, -32'sd2048, 0, 32'h80012283, 2'd0);
        vecs[13] = mk("auipc_big",7'h17, 1, 0, 0, 3'd0, 7'h00, 32'd5000,  0, 32'h0,        2'd1);

        rst = 1; start = 0; start2 = 0;
        bus.in_valid = 0; bus.in_opcode = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
        bus.in_funct3 = 0; bus.in_funct7 = 0; bus.in_imm = 0; bus.in_last = 0;
        bus2.in_valid = 0; bus2.in_opcode = 0; bus2.in_rd = 0; bus2.in_rs1 = 0; bus2.in_rs2 = 0;
        bus2.in_funct3 = 0; bus2.in_funct7 = 0; bus2.in_imm = 0; bus2.in_last = 0;
        @(posedge clk); #1;
        cycle();
        rst = 0;
        chk("reset_outputs", {27'(count), err_code, err, done, busy}, 32'd0);

        for (int i = 0; i < 14; i++) begin
            pulse_start();
            drive(vecs[i]);
            cycle();
            bus.in_valid = 0;
            chk({vecs[i].name, "_we"}, 32'(bus.imem_we), 32'(vecs[i].code == 0));
            chk({vecs[i].name, "_code"}, 32'(err_code), 32'(vecs[i].code));
            if (vecs[i].code == 0) chk({vecs[i].name, "_word"}, bus.imem_wdata, vecs[i].word);
        end

        pulse_start();
        drive(vecs[1]); cycle();
        chk("b2b_addr0", 32'(bus.imem_addr), 32'd0);
        chk("b2b_word0", bus.imem_wdata, 32'h0020A423);
        drive(vecs[2]); cycle();
        chk("b2b_we1", 32'(bus.imem_we), 32'd1);
        chk("b2b_addr1", 32'(bus.imem_addr), 32'd1);
        chk("b2b_word1", bus.imem_wdata, 32'hFE208EE3);
        drive(vecs[3]); cycle();
        bus.in_valid = 0;
        chk("jal_done", {29'd0, done, busy, bus.in_ready}, 32'b100);
        chk("jal_count", 32'(count), 32'd3);
        drive(vecs[0]); cycle(); cycle();
        bus.in_valid = 0;
        chk("done_sticky_count", 32'(count), 32'd3);

        pulse_start();
        drive(vecs[4]); cycle();
        bus.in_valid = 0;
        chk("err_set", {30'd0, err, busy}, 32'b10);
        pulse_start();
        chk("start_clears_err", {29'd0, err, err_code}, 32'd0);

        drive(vecs[0]); cycle(); cycle(); cycle();
        rst = 1; cycle();
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_all", {27'(count), err_code, err, done, busy}, 32'd0);
        rst = 0; cycle(); cycle();
        bus.in_valid = 0;
        chk("after_rst_idle", {30'd0, bus.in_ready, bus.imem_we}, 32'd0);

        start2 = 1; cycle(); start2 = 0;
        bus2.in_valid = 1; bus2.in_opcode = 7'h13; bus2.in_rd = 1; bus2.in_imm = 5;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("ovf_we", 32'(bus2.imem_we), 32'd1);
            chk("ovf_addr", 32'(bus2.imem_addr), 32'(i));
            chk("ovf_word", bus2.imem_wdata, 32'h00500093);
        end
        cycle();
        bus2.in_valid = 0;
        chk("ovf_no_write", 32'(bus2.imem_we), 32'd0);
        chk("ovf_code", {29'd0, err2, err_code2}, 32'b111);
        chk("ovf_count", 32'(count2), 32'd4);
        chk("ovf_ready", 32'(bus2.in_ready), 32'd0);

        pulse_start();
        for (int n = 0; n < 3000; n++) begin
            int sel;
            start = $urandom_range(0, 99) < 3;
            rst = $urandom_range(0, 999) < 3;
            bus.in_valid = $urandom_range(0, 3) != 0;
            bus.in_opcode = ops[$urandom_range(0, 8)];
            bus.in_rd = 5'($urandom); bus.in_rs1 = 5'($urandom); bus.in_rs2 = 5'($urandom);
            bus.in_funct3 = 3'($urandom); bus.in_funct7 = 7'($urandom);
            sel = $urandom_range(0, 9);
            bus.in_imm = sel < 6 ? 32'($urandom_range(0, 80)) - 32'd40 :
                         sel < 9 ? 32'(bnd[$urandom_range(0, 17)]) : $urandom;
            bus.in_last = $urandom_range(0, 49) == 0;
            cycle();
        end
        start = 0; rst = 0; bus.in_valid = 0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
